// File: rtl/apb2_mult_master_if.sv
// apb2_mult_master_if
//   Bundles the signals of the multiply requester: the request port, the
//   response port, the busy flag and the APB2 requester bus.
//
//   Request  : req_valid, req_ready, req_a[7:0], req_b[7:0]
//   Response : rsp_valid, rsp_ready, rsp_product[15:0], rsp_timeout
//   Status   : busy
//   APB      : psel, penable, pwrite, paddr[9:0] (word address), pwdata[31:0],
//              prdata[31:0]
//
//   modport master : the requester's view (drives the APB bus and the
//                    handshake outputs).
//   modport slave  : the environment's view (user logic plus APB peripheral).
interface apb2_mult_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_product;
  logic        rsp_timeout;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, prdata,
    output req_ready, rsp_valid, rsp_product, rsp_timeout, busy,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, prdata,
    input  req_ready, rsp_valid, rsp_product, rsp_timeout, busy,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb2_mult_master.sv
// apb2_mult_master
//   APB2 requester that runs one signed 8x8 multiply on the APB multiplier
//   peripheral per accepted request. The sequence is: write multiplier
//   (word 0), write multiplicand (word 1), write start (word 2 = 1), poll
//   word 2 until bit 1 (done) is set, then read the product (word 3). The
//   product is handed back unmodified on the response port.
//
//   Parameters
//     POLL_GAP  : idle cycles between consecutive status polls (0..256).
//     MAX_POLLS : status reads issued before reporting a timeout (1..255).
//
//   Ports
//     pclk   : clock, all logic on the rising edge.
//     preset : synchronous active-high reset.
//     bus    : apb2_mult_master_if.master (request, response, busy, APB).
module apb2_mult_master #(
  parameter int POLL_GAP  = 2,
  parameter int MAX_POLLS = 64
) (
  input  logic               pclk,
  input  logic               preset,
  apb2_mult_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MER,
    S_W_MCAND,
    S_W_CMD,
    S_POLL,
    S_GAP,
    S_R_RES,
    S_RESP
  } state_t;

  localparam logic [9:0] ADDR_MER    = 10'd0;
  localparam logic [9:0] ADDR_MCAND  = 10'd1;
  localparam logic [9:0] ADDR_CMD    = 10'd2;
  localparam logic [9:0] ADDR_RESULT = 10'd3;
  localparam logic [7:0] POLL_LIMIT  = 8'(MAX_POLLS);
  localparam logic [7:0] GAP_LAST    = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_access;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [7:0]  r_pollCnt;
  logic [7:0]  r_gapCnt;
  logic [15:0] r_product;
  logic        r_timeout;
  logic        r_busy;

  logic        w_inXfer;
  logic [7:0]  w_pollNext;
  logic        w_statusDone;
  logic        w_pollExpired;

  // Only the done flag and the low half of the result word carry meaning.
  wire w_unusedPrdata = &{1'b0, bus.prdata[31:16]};

  // r_access is the APB phase bit inside a transfer state: 0 = SETUP,
  // 1 = ACCESS. Every transfer state leaves on the edge that ends ACCESS.
  assign w_inXfer = (r_state == S_W_MER)   || (r_state == S_W_MCAND) ||
                    (r_state == S_W_CMD)   || (r_state == S_POLL)    ||
                    (r_state == S_R_RES);

  // Poll count saturates so a misconfigured limit can never wrap to zero.
  assign w_pollNext    = (r_pollCnt == 8'hFF) ? 8'hFF : r_pollCnt + 8'd1;
  assign w_statusDone  = bus.prdata[1];
  assign w_pollExpired = (w_pollNext == POLL_LIMIT);

  assign bus.rsp_product = r_product;
  assign bus.rsp_timeout = r_timeout;
  assign bus.busy        = r_busy;

  // Next-state and bus decode. Address, direction and write data depend only
  // on the state, so they hold steady across SETUP and ACCESS; penable simply
  // follows the phase bit.
  always_comb begin
    w_stateNext   = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    bus.pwrite    = 1'b0;
    bus.paddr     = '0;
    bus.pwdata    = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_stateNext = S_W_MER;
      end
      S_W_MER: begin
        bus.psel    = 1'b1;
        bus.penable = r_access;
        bus.pwrite  = 1'b1;
        bus.paddr   = ADDR_MER;
        bus.pwdata  = {24'd0, r_a};
        if (r_access) w_stateNext = S_W_MCAND;
      end
      S_W_MCAND: begin
        bus.psel    = 1'b1;
        bus.penable = r_access;
        bus.pwrite  = 1'b1;
        bus.paddr   = ADDR_MCAND;
        bus.pwdata  = {24'd0, r_b};
        if (r_access) w_stateNext = S_W_CMD;
      end
      S_W_CMD: begin
        bus.psel    = 1'b1;
        bus.penable = r_access;
        bus.pwrite  = 1'b1;
        bus.paddr   = ADDR_CMD;
        bus.pwdata  = 32'h1;
        if (r_access) w_stateNext = S_POLL;
      end
      S_POLL: begin
        bus.psel    = 1'b1;
        bus.penable = r_access;
        bus.paddr   = ADDR_CMD;
        if (r_access) begin
          if (w_statusDone)       w_stateNext = S_R_RES;
          else if (w_pollExpired) w_stateNext = S_RESP;
          else if (POLL_GAP == 0) w_stateNext = S_POLL;
          else                    w_stateNext = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gapCnt == GAP_LAST) w_stateNext = S_POLL;
      end
      S_R_RES: begin
        bus.psel    = 1'b1;
        bus.penable = r_access;
        bus.paddr   = ADDR_RESULT;
        if (r_access) w_stateNext = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // State register plus datapath. Reset drops any in-flight request: the
  // state returns to IDLE, so the bus is released and no response follows.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_access  <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_pollCnt <= '0;
      r_gapCnt  <= '0;
      r_product <= '0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_access <= w_inXfer & ~r_access;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_a       <= bus.req_a;
            r_b       <= bus.req_b;
            r_pollCnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_POLL: begin
          if (r_access) begin
            r_pollCnt <= w_pollNext;
            r_gapCnt  <= '0;
            if (!w_statusDone && w_pollExpired) begin
              r_timeout <= 1'b1;
              r_product <= '0;
            end
          end
        end
        S_GAP: r_gapCnt <= r_gapCnt + 8'd1;
        S_R_RES: begin
          if (r_access) begin
            r_product <= bus.prdata[15:0];
            r_timeout <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
